// File: rtl/ps2_pkg.sv
// Scan-code set 2 constants and decoder state encoding, shared with the game datapath.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_SKIP    = 3'd4
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_UP    = 8'h75;

  // Keyboard status/handshake bytes that carry no key information.
  function automatic logic is_ignored(input logic [7:0] b);
    return b inside {PS2_BAT, PS2_ACK, PS2_RESEND, PS2_ECHO, PS2_ERR0, PS2_ERR1};
  endfunction

  // Bytes that cannot legally follow a prefix.
  function automatic logic is_bad_mid(input logic [7:0] b);
    return b inside {PS2_EXT, PS2_BRK, PS2_PAUSE, PS2_ERR0, PS2_ERR1};
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte-in / key-state-out bundle between the PS/2 receiver, decoder and datapath.
interface ps2_key_decoder_if;
  logic [7:0] ps2_byte;
  logic       ps2_byte_valid;
  logic [7:0] keycode;
  logic       key_make;
  logic       key_ext;
  logic       key_event;
  logic       event_break;
  logic       seq_error;

  modport master (
    output ps2_byte, ps2_byte_valid,
    input  keycode, key_make, key_ext, key_event, event_break, seq_error
  );

  modport slave (
    input  ps2_byte, ps2_byte_valid,
    output keycode, key_make, key_ext, key_event, event_break, seq_error
  );
endinterface

// File: rtl/ps2_seq_timer.sv
// Loadable up-counter with clear; done flags the last cycle before LIMIT.
module ps2_seq_timer #(
  parameter int W     = 17,
  parameter int LIMIT = 100_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (load) cnt_d = load_val;
    else if (en)   cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/ps2_key_decoder.sv
// Set-2 scan-code decoder: prefix FSM producing held key state plus event/error pulses.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter int TO_W           = 17,
  parameter int PAUSE_SKIP     = 7
) (
  input  logic               clk,
  input  logic               reset,
  ps2_key_decoder_if.slave   bus
);

  localparam int SK_W = $clog2(PAUSE_SKIP + 1);

  ps2_state_e      state_q, state_d;
  logic [SK_W-1:0] skip_q, skip_d;
  logic [7:0]      keycode_q, keycode_d;
  logic            make_q, make_d, ext_q, ext_d;
  logic            event_q, event_d, brk_q, brk_d, err_q, err_d;
  logic            to_done, timeout;
  logic [7:0]      b;

  assign b       = bus.ps2_byte;
  // A byte arriving on the timeout cycle takes priority.
  assign timeout = to_done && !bus.ps2_byte_valid && (state_q != S_IDLE);

  ps2_seq_timer #(.W(TO_W), .LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (bus.ps2_byte_valid || timeout),
    .en       (state_q != S_IDLE),
    .load     (1'b0),
    .load_val ({TO_W{1'b0}}),
    .done     (to_done)
  );

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    keycode_d = keycode_q;
    make_d    = make_q;
    ext_d     = ext_q;
    event_d   = 1'b0;
    brk_d     = 1'b0;
    err_d     = 1'b0;
    if (bus.ps2_byte_valid) begin
      case (state_q)
        S_IDLE: begin
          if (b == PS2_EXT)        state_d = S_EXT;
          else if (b == PS2_BRK)   state_d = S_BRK;
          else if (b == PS2_PAUSE) begin
            state_d = S_SKIP;
            skip_d  = SK_W'(PAUSE_SKIP);
          end else if (!is_ignored(b)) begin
            keycode_d = b;
            ext_d     = 1'b0;
            make_d    = 1'b1;
            event_d   = 1'b1;
          end
        end
        S_EXT: begin
          if (b == PS2_BRK) state_d = S_EXT_BRK;
          else begin
            state_d = S_IDLE;
            if (is_bad_mid(b)) err_d = 1'b1;
            else begin
              keycode_d = b;
              ext_d     = 1'b1;
              make_d    = 1'b1;
              event_d   = 1'b1;
            end
          end
        end
        S_BRK, S_EXT_BRK: begin
          state_d = S_IDLE;
          if (is_bad_mid(b)) err_d = 1'b1;
          else begin
            event_d = 1'b1;
            brk_d   = 1'b1;
            // Only releasing the held key (same code, same extension) drops key_make.
            if (b == keycode_q && ((state_q == S_EXT_BRK) == ext_q)) make_d = 1'b0;
          end
        end
        S_SKIP: begin
          skip_d = skip_q - SK_W'(1);
          if (skip_q <= SK_W'(1)) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      skip_q    <= '0;
      keycode_q <= '0;
      make_q    <= 1'b0;
      ext_q     <= 1'b0;
      event_q   <= 1'b0;
      brk_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      keycode_q <= keycode_d;
      make_q    <= make_d;
      ext_q     <= ext_d;
      event_q   <= event_d;
      brk_q     <= brk_d;
      err_q     <= err_d;
    end
  end

  assign bus.keycode     = keycode_q;
  assign bus.key_make    = make_q;
  assign bus.key_ext     = ext_q;
  assign bus.key_event   = event_q;
  assign bus.event_break = brk_q;
  assign bus.seq_error   = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with hand-computed expectations.
module tb_ps2_key_decoder;

  localparam int TO = 200;

  logic clk = 1'b0;
  logic reset;
  int   chk_cnt = 0, pass_cnt = 0;
  int   ev_cnt = 0, err_cnt = 0, bad_brk = 0;
  int   ev0, er0, n;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .TO_W(17), .PAUSE_SKIP(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulse tallies; read before the DUT's NBA update, so each counts the previous cycle.
  always @(posedge clk) begin
    if (bus.key_event) ev_cnt++;
    if (bus.seq_error) err_cnt++;
    if (bus.event_break && !bus.key_event) bad_brk++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Called on a negedge; the byte is sampled on the next posedge and returns on the following negedge.
  task automatic send(input logic [7:0] b);
    bus.ps2_byte       = b;
    bus.ps2_byte_valid = 1'b1;
    @(negedge clk);
    bus.ps2_byte_valid = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    reset = 1'b1;
    bus.ps2_byte = 8'h00;
    bus.ps2_byte_valid = 1'b0;
    idle(2);
    chk("rst keycode", bus.keycode, 0);
    chk("rst outs", {bus.key_make, bus.key_ext, bus.key_event, bus.event_break, bus.seq_error}, 0);
    reset = 1'b0;
    idle(1);

    // extended make then matching extended break
    send(8'hE0);
    chk("e0 no event", bus.key_event, 0);
    send(8'h75);
    chk("ext make code", bus.keycode, 8'h75);
    chk("ext make flags", {bus.key_ext, bus.key_make, bus.key_event, bus.event_break}, 4'b1110);
    idle(1);
    chk("event one cycle", bus.key_event, 0);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext break flags", {bus.key_make, bus.key_event, bus.event_break}, 3'b011);
    chk("ext break code", {bus.keycode, bus.key_ext}, {8'h75, 1'b1});

    // extension mismatch leaves key held
    send(8'h1C);
    chk("make 1c", {bus.keycode, bus.key_ext, bus.key_make}, {8'h1C, 2'b01});
    send(8'hE0); send(8'hF0); send(8'h1C);
    chk("mismatch brk", {bus.key_make, bus.key_event, bus.event_break}, 3'b111);
    send(8'hF0); send(8'h1C);
    chk("match brk", {bus.key_make, bus.event_break}, 2'b01);

    // typematic repeats
    idle(1); ev0 = ev_cnt;
    for (int i = 0; i < 3; i++) begin
      send(8'hE0); send(8'h74);
      chk("typematic", {bus.key_make, bus.key_event, bus.keycode}, {2'b11, 8'h74});
    end
    idle(1);
    chk("typematic events", ev_cnt - ev0, 3);

    // ignored bytes, then illegal byte after prefix
    ev0 = ev_cnt;
    send(8'hAA); send(8'hFA); send(8'h00); idle(1);
    chk("ignored no event", ev_cnt - ev0, 0);
    send(8'hE0); send(8'hE0);
    chk("e0 e0 error", bus.seq_error, 1);
    chk("err holds state", {bus.keycode, bus.key_make, bus.key_ext}, {8'h74, 2'b11});
    idle(1);
    chk("error one cycle", bus.seq_error, 0);

    // pause sequence is swallowed
    idle(1); ev0 = ev_cnt; er0 = err_cnt;
    for (int i = 0; i < 8; i++) send(pause_seq[i]);
    idle(1);
    chk("pause no event", ev_cnt - ev0, 0);
    chk("pause no error", err_cnt - er0, 0);
    chk("pause held", {bus.keycode, bus.key_make, bus.key_ext}, {8'h74, 2'b11});
    send(8'h6B);
    chk("make after pause", {bus.keycode, bus.key_ext, bus.key_make, bus.key_event}, {8'h6B, 3'b011});

    // timeout after a stranded E0
    send(8'hE0);
    n = 0;
    while (!bus.seq_error && n < TO + 10) begin
      @(negedge clk);
      n++;
    end
    chk("timeout cycle", n, TO);
    chk("timeout held", {bus.keycode, bus.key_make}, {8'h6B, 1'b1});
    idle(1);
    chk("timeout one cycle", bus.seq_error, 0);
    send(8'h72);
    chk("make after timeout", {bus.keycode, bus.key_ext, bus.key_make}, {8'h72, 2'b01});

    // byte on the timeout cycle wins
    idle(1); er0 = err_cnt;
    send(8'hE0);
    idle(TO - 1);
    send(8'h75);
    chk("byte wins flags", {bus.seq_error, bus.key_ext, bus.key_event}, 3'b011);
    chk("byte wins code", bus.keycode, 8'h75);
    idle(TO + 5);
    chk("byte wins no err", err_cnt - er0, 0);

    // reset mid-sequence
    er0 = err_cnt;
    send(8'hF0);
    reset = 1'b1;
    #1;
    chk("async rst outs", {bus.keycode, bus.key_make, bus.key_ext}, 0);
    @(negedge clk);
    reset = 1'b0;
    send(8'h72);
    chk("post rst make", {bus.keycode, bus.key_ext, bus.key_make, bus.key_event, bus.event_break},
        {8'h72, 4'b0110});
    idle(TO + 5);
    chk("post rst no err", err_cnt - er0, 0);
    chk("brk without event", bad_brk, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
